// File: rtl/arc4_pkg.sv
// Shared ARC4 types: byte type, PRGA state encoding and per-byte cycle cost.
package arc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int PRGA_CYC_PER_BYTE = 7;

  typedef enum logic [3:0] {
    IDLE,
    LEN_RD,
    LEN_WR,
    I_RD,
    J_ADDR,
    J_RD,
    SWAP_I,
    SWAP_J,
    PAD_RD,
    PAD_WR
  } prga_state_t;

endpackage

// File: rtl/arc4_prga.sv
// ARC4 PRGA stage: decrypts a length-prefixed ciphertext using the S-box left by ksa,
// swapping S entries in place and writing a length-prefixed plaintext.
module arc4_prga
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  prga_state_t state;

  byte_t i, j, k, len, si, sj, ctb;

  // Sequencer and datapath registers; every memory read lands one state after its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= 8'd0;
      j     <= 8'd0;
      k     <= 8'd0;
      len   <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
      ctb   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            i     <= 8'd1;
            j     <= 8'd0;
            k     <= 8'd1;
            state <= LEN_RD;
          end
        end
        LEN_RD: state <= LEN_WR;
        LEN_WR: begin
          len   <= ct_rddata;
          state <= (ct_rddata == 8'd0) ? IDLE : I_RD;
        end
        I_RD: state <= J_ADDR;
        J_ADDR: begin
          si    <= s_rddata;
          ctb   <= ct_rddata;
          j     <= j + s_rddata;
          state <= J_RD;
        end
        J_RD: state <= SWAP_I;
        SWAP_I: begin
          sj    <= s_rddata;
          state <= SWAP_J;
        end
        SWAP_J: state <= PAD_RD;
        PAD_RD: state <= PAD_WR;
        PAD_WR: begin
          if (k == len) begin
            state <= IDLE;
          end else begin
            k     <= k + 8'd1;
            i     <= i + 8'd1;
            state <= I_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-facing outputs decode from state so each write commits on the edge leaving it.
  always_comb begin
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;
    case (state)
      IDLE: rdy = 1'b1;
      LEN_RD: ct_addr = 8'd0;
      LEN_WR: begin
        pt_addr   = 8'd0;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      I_RD: begin
        s_addr  = i;
        ct_addr = k;
      end
      J_RD: s_addr = j;
      SWAP_I: begin
        s_addr   = i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      SWAP_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
      end
      PAD_RD: s_addr = si + sj;
      PAD_WR: begin
        pt_addr   = k;
        pt_wrdata = s_rddata ^ ctb;
        pt_wren   = 1'b1;
      end
      default: rdy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_arc4_prga.sv
// Self-checking bench for arc4_prga: behavioural memories plus a queue of expected
// plaintext writes produced by an independent ARC4 reference model.
module tb_arc4_prga;
  import arc4_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  byte_t smem   [256];
  byte_t s_init [256];
  byte_t ms     [256];
  byte_t ct_mem [256];
  logic  s_load;

  logic [16:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  arc4_prga dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rdy      (rdy),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren),
    .ct_addr  (ct_addr),
    .ct_rddata(ct_rddata),
    .pt_addr  (pt_addr),
    .pt_wrdata(pt_wrdata),
    .pt_wren  (pt_wren)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; s_load lets the bench preload S while the DUT is idle.
  always @(posedge clk) begin
    cyc_cnt   <= cyc_cnt + 1;
    s_rddata  <= smem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (s_load) begin
      for (int a = 0; a < 256; a++) smem[a] <= s_init[a];
    end else if (s_wren) begin
      smem[s_addr] <= s_wrdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic doLoad();
    @(negedge clk);
    s_load = 1'b1;
    @(negedge clk);
    s_load = 1'b0;
  endtask

  task automatic loadIdentity();
    for (int a = 0; a < 256; a++) begin
      s_init[a] = byte_t'(a);
      ms[a]     = byte_t'(a);
    end
    doLoad();
  endtask

  task automatic loadKsa(input logic [23:0] key);
    byte_t kj, t, kb;
    kj = 8'd0;
    for (int a = 0; a < 256; a++) s_init[a] = byte_t'(a);
    for (int a = 0; a < 256; a++) begin
      case (a % 3)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      kj = kj + s_init[a] + kb;
      t = s_init[a];
      s_init[a] = s_init[kj];
      s_init[kj] = t;
    end
    for (int a = 0; a < 256; a++) ms[a] = s_init[a];
    doLoad();
  endtask

  // Reference ARC4 PRGA over the model copy of S; optionally queues the expected writes.
  task automatic modelRun(input bit push);
    byte_t mi, mj, t, pad;
    int    n;
    n  = int'(ct_mem[0]);
    mi = 8'd1;
    mj = 8'd0;
    if (push) exp_q.push_back({1'b0, 8'h00, ct_mem[0]});
    for (int kk = 1; kk <= n; kk++) begin
      mj = mj + ms[mi];
      t = ms[mi];
      ms[mi] = ms[mj];
      ms[mj] = t;
      pad = ms[byte_t'(ms[mi] + ms[mj])];
      if (push) exp_q.push_back({1'b0, byte_t'(kk), ct_mem[kk] ^ pad});
      mi = mi + 8'd1;
    end
  endtask

  // en_mode: 0 single pulse, 1 held high, 2 random toggling while busy.
  task automatic applyStimulus(input string name, input int en_mode, input int abort_at);
    int          len, n, t0, pt_cnt, s_cnt, first_pt, rdy_edge, mism;
    bit          done;
    logic [16:0] exp_w;
    len      = int'(ct_mem[0]);
    pt_cnt   = 0;
    s_cnt    = 0;
    first_pt = -1;
    rdy_edge = -1;
    n        = 0;
    done     = 1'b0;
    $display("[TB] run %s len=%0d", name, len);
    @(negedge clk);
    en = 1'b1;
    t0 = cyc_cnt + 1;
    while (!done) begin
      @(negedge clk);
      n++;
      if (pt_wren) begin
        pt_cnt++;
        if (pt_addr == 8'd0 && first_pt < 0) first_pt = cyc_cnt + 1;
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h10000;
        checkOutput({name, "_pt_write"}, {15'd0, 1'b0, pt_addr, pt_wrdata}, {15'd0, exp_w});
      end
      if (s_wren) s_cnt++;
      if (n == 1) checkOutput({name, "_rdy_drop"}, rdy, 0);
      if (rdy) begin
        rdy_edge = cyc_cnt + 1;
        done     = 1'b1;
        en       = 1'b0;
      end else if (n >= 3000) begin
        done = 1'b1;
        en   = 1'b0;
      end else begin
        case (en_mode)
          1:       en = 1'b1;
          2:       en = 1'($urandom_range(0, 1));
          default: en = 1'b0;
        endcase
      end
      if (abort_at > 0 && n == abort_at && !done) begin
        en  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput({name, "_abort_rdy"}, rdy, 1);
        checkOutput({name, "_abort_s_wren"}, s_wren, 0);
        checkOutput({name, "_abort_pt_wren"}, pt_wren, 0);
        rst = 1'b0;
        exp_q.delete();
        return;
      end
    end
    checkOutput({name, "_pt0_edge"}, first_pt - t0, 2);
    checkOutput({name, "_rdy_latency"}, rdy_edge - t0, 3 + PRGA_CYC_PER_BYTE * len);
    checkOutput({name, "_pt_count"}, pt_cnt, len + 1);
    checkOutput({name, "_s_wr_count"}, s_cnt, 2 * len);
    checkOutput({name, "_sb_drained"}, exp_q.size(), 0);
    @(negedge clk);
    mism = 0;
    for (int a = 0; a < 256; a++) if (smem[a] !== ms[a]) mism++;
    checkOutput({name, "_s_final"}, mism, 0);
  endtask

  task automatic loadKnownCt();
    byte_t kv_ct [9];
    kv_ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    ct_mem[0] = 8'd9;
    for (int a = 0; a < 9; a++) ct_mem[a + 1] = kv_ct[a];
  endtask

  initial begin
    byte_t kv_pt [9];
    kv_pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    rst    = 1'b1;
    en     = 1'b0;
    s_load = 1'b0;
    for (int a = 0; a < 256; a++) begin
      ct_mem[a] = 8'd0;
      smem[a]   = 8'd0;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset_rdy", rdy, 1);
    checkOutput("reset_s_wren", s_wren, 0);
    checkOutput("reset_pt_wren", pt_wren, 0);
    checkOutput("reset_addrs", {s_addr, ct_addr, pt_addr}, 0);
    checkOutput("reset_wrdata", {s_wrdata, pt_wrdata}, 0);
    rst = 1'b0;

    // Empty message
    loadIdentity();
    ct_mem[0] = 8'd0;
    modelRun(1'b1);
    applyStimulus("empty", 0, 0);

    // Identity S, single zero byte: i=j=1, pad = S[2] = 2
    loadIdentity();
    ct_mem[0] = 8'd1;
    ct_mem[1] = 8'h00;
    modelRun(1'b0);
    exp_q.push_back({1'b0, 8'h00, 8'h01});
    exp_q.push_back({1'b0, 8'h01, 8'h02});
    applyStimulus("ident1", 0, 0);

    // Known vector: key "Key", ciphertext decrypts to "Plaintext"
    loadKsa(24'h4B6579);
    loadKnownCt();
    modelRun(1'b0);
    exp_q.push_back({1'b0, 8'h00, 8'h09});
    for (int a = 0; a < 9; a++) exp_q.push_back({1'b0, byte_t'(a + 1), kv_pt[a]});
    applyStimulus("known", 0, 0);

    // en held high, then randomly re-pulsed while busy, continuing on the evolved S
    ct_mem[0] = 8'd5;
    for (int a = 1; a <= 5; a++) ct_mem[a] = byte_t'($urandom_range(0, 255));
    modelRun(1'b1);
    applyStimulus("en_hold", 1, 0);
    for (int a = 1; a <= 5; a++) ct_mem[a] = byte_t'($urandom_range(0, 255));
    modelRun(1'b1);
    applyStimulus("en_toggle", 2, 0);

    // Reset in the middle of byte 3, then a clean rerun
    loadKsa(24'h4B6579);
    loadKnownCt();
    modelRun(1'b1);
    applyStimulus("abort", 0, 20);
    loadKsa(24'h4B6579);
    exp_q.push_back({1'b0, 8'h00, 8'h09});
    for (int a = 0; a < 9; a++) exp_q.push_back({1'b0, byte_t'(a + 1), kv_pt[a]});
    modelRun(1'b0);
    applyStimulus("rerun", 0, 0);

    // Maximum length message on identity S
    loadIdentity();
    ct_mem[0] = 8'd255;
    for (int a = 1; a <= 255; a++) ct_mem[a] = byte_t'($urandom_range(0, 255));
    modelRun(1'b1);
    applyStimulus("maxlen", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
